// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM state encodings, opcode values,
// the captured memory-request record and the timeout sizing.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } lsu_state_t;

    localparam logic [3:0] OP_LOAD = 4'b0110;
    localparam logic [3:0] OP_STOR = 4'b0111;

    localparam int TIMEOUT_CYCLES = 15;
    localparam int TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1);

    typedef struct packed {
        logic        we;
        logic [14:0] addr;
        logic [15:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/load_store_unit_timeout_counter.sv
// Counts BUSY cycles without ack and flags when the abort limit is reached.
// Saturates at the limit so it never wraps.
module lsu_timeout_counter
    import load_store_unit_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_CYCLES,
    parameter int W     = TIMEOUT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic limit_reached
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !limit_reached) begin
            count <= count + 1'b1;
        end
    end

    // The count seen during the N-th wait cycle is N-1, so the abort lands after LIMIT cycles.
    assign limit_reached = (count == W'(LIMIT - 1));

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: req/ack handshake with word-wide data memory, core stall and
// load write-back. Define LSU_TIMEOUT_EN to enable the BUSY timeout and bus_err flag.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        store,
    input  logic [15:0] address,
    input  logic [15:0] store_data,
    input  logic [2:0]  dest_reg,
    input  logic        err_clr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        stall,
    output logic        wb_valid,
    output logic [2:0]  wb_reg,
    output logic [15:0] wb_data,
    output logic        misalign_err,
    output logic        bus_err
);

    lsu_state_t state, state_next;
    mem_req_t   req_q;
    logic       go;
    logic       misaligned;
    logic       ack_done;
    logic       timeout;

    assign go         = (state == IDLE) && (load || store);
    assign misaligned = address[0];
    assign ack_done   = (state == BUSY) && mem_ack;

`ifdef LSU_TIMEOUT_EN
    logic limit_reached;

    lsu_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (TIMEOUT_W)
    ) u_timeout (
        .clk           (clk),
        .reset         (reset),
        .clear         (go && !misaligned),
        .inc           ((state == BUSY) && !mem_ack),
        .limit_reached (limit_reached)
    );

    // An ack on the limit edge takes priority and completes the access normally.
    assign timeout = (state == BUSY) && !mem_ack && limit_reached;
`else
    assign timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assignment first, so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:    if (load || store) state_next = misaligned ? DONE : BUSY;
            BUSY:    if (mem_ack || timeout) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall = go || (state == BUSY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q        <= '0;
            mem_req      <= 1'b0;
            wb_valid     <= 1'b0;
            wb_reg       <= '0;
            wb_data      <= '0;
            misalign_err <= 1'b0;
        end else begin
            wb_valid <= ack_done && !req_q.we;

            if (go && !misaligned) begin
                // Load wins when both decodes are asserted.
                req_q   <= '{we: store && !load, addr: address[15:1], wdata: store_data};
                wb_reg  <= dest_reg;
                mem_req <= 1'b1;
            end else if (ack_done || timeout) begin
                mem_req <= 1'b0;
            end

            if (ack_done && !req_q.we) begin
                wb_data <= mem_rdata;
            end

            if (go && misaligned) begin
                misalign_err <= 1'b1;
            end else if (err_clr) begin
                misalign_err <= 1'b0;
            end
        end
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_err <= 1'b0;
        end else if (timeout) begin
            bus_err <= 1'b1;
        end else if (err_clr) begin
            bus_err <= 1'b0;
        end
    end
`else
    assign bus_err = 1'b0;
`endif

    assign mem_we    = req_q.we;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver issues instructions and predicts bus
// requests and write-backs; a memory responder and a write-back monitor check them.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic        store = 1'b0;
    logic [15:0] address = '0;
    logic [15:0] store_data = '0;
    logic [2:0]  dest_reg = '0;
    logic        err_clr = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        stall;
    logic        wb_valid;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic        misalign_err;
    logic        bus_err;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .store        (store),
        .address      (address),
        .store_data   (store_data),
        .dest_reg     (dest_reg),
        .err_clr      (err_clr),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .misalign_err (misalign_err),
        .bus_err      (bus_err)
    );

    typedef struct {
        logic [14:0] addr;
        logic        we;
        logic [15:0] wdata;
    } req_t;

    typedef struct {
        logic [2:0]  rg;
        logic [15:0] data;
    } wb_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    req_t req_q[$];
    wb_t  wb_q[$];
    logic [15:0] ref_mem[int];
    logic [15:0] dev_mem[int];

    bit   exp_mis = 0;
    bit   exp_bus = 0;
    bit   prev_acked = 0;
    bit   chk_b2b = 0;
    int   dev_lat = 0;
    int   busy_n = 0;
    int   last_ack_cyc = 0;
    logic [31:0] held_req = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] init_word(input int w);
        return 16'(w * 40503 + 4951);
    endfunction

    function automatic logic [15:0] ref_rd(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    function automatic logic [15:0] dev_rd(input int w);
        return dev_mem.exists(w) ? dev_mem[w] : init_word(w);
    endfunction

    // Memory responder: checks each new request, holds it stable, acks after dev_lat cycles.
    always @(negedge clk) begin
        if (!reset) begin
            busy_n  = 0;
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (busy_n == 0) begin
                check("req_pending", 32'(req_q.size() != 0), 32'd1);
                if (req_q.size() != 0) begin
                    req_t e;
                    e = req_q.pop_front();
                    check("req_addr", 32'(mem_addr), 32'(e.addr));
                    check("req_we", 32'(mem_we), 32'(e.we));
                    if (e.we) check("req_wdata", 32'(mem_wdata), 32'(e.wdata));
                end
                if (chk_b2b) check("b2b_gap", cyc - last_ack_cyc, 32'd2);
                chk_b2b  = 0;
                held_req = {mem_we, mem_addr, mem_wdata};
            end else begin
                check("req_stable", {mem_we, mem_addr, mem_wdata}, held_req);
            end
            busy_n++;
            if (dev_lat != 0 && busy_n == dev_lat) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    dev_mem[int'(mem_addr)] = mem_wdata;
                    mem_rdata = 16'($urandom);
                end else begin
                    mem_rdata = dev_rd(int'(mem_addr));
                end
                last_ack_cyc = cyc + 1;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
            end
        end else begin
            busy_n    = 0;
            mem_ack   = ($urandom_range(0, 3) == 0);
            mem_rdata = 16'($urandom);
        end
    end

    // Write-back monitor.
    always @(negedge clk) begin
        if (reset && wb_valid) begin
            check("wb_pending", 32'(wb_q.size() != 0), 32'd1);
            if (wb_q.size() != 0) begin
                wb_t e;
                e = wb_q.pop_front();
                check("wb_reg", 32'(wb_reg), 32'(e.rg));
                check("wb_data", 32'(wb_data), 32'(e.data));
            end
        end
    end

    // lat: BUSY cycle in which memory acks (0 = never). Called at posedge+1.
    task automatic issue(input bit ld, input bit st, input logic [15:0] a, input logic [15:0] d,
                         input logic [2:0] r, input int lat, input bit clr);
        bit mis;
        bit timed_out;
        int exp_occ;
        int occ;
        int w;
        mis       = a[0];
        w         = int'(a[15:1]);
        timed_out = 0;
`ifdef LSU_TIMEOUT_EN
        if (!mis && (lat == 0 || lat > TIMEOUT_CYCLES)) timed_out = 1;
`endif
        exp_occ = mis ? 2 : (timed_out ? 2 + TIMEOUT_CYCLES : 2 + lat);
        if (clr) begin
            exp_mis = 0;
            exp_bus = 0;
        end
        if (mis) exp_mis = 1;
        if (timed_out) exp_bus = 1;
        if (!mis) begin
            req_q.push_back('{addr: a[15:1], we: st && !ld, wdata: d});
            if (!timed_out) begin
                if (ld) wb_q.push_back('{rg: r, data: ref_rd(w)});
                else ref_mem[w] = d;
            end
        end
        dev_lat = lat;
        chk_b2b = prev_acked && !mis;

        load = ld; store = st; address = a; store_data = d; dest_reg = r; err_clr = clr;
        occ = 0;
        forever begin
            @(negedge clk);
            occ++;
            if (!stall || occ >= 100) break;
            @(posedge clk);
            #1 err_clr = 1'b0;
        end
        check("occupancy", occ, exp_occ);
        check("misalign_err", 32'(misalign_err), 32'(exp_mis));
        check("bus_err", 32'(bus_err), 32'(exp_bus));
        @(posedge clk);
        #1;
        load = 1'b0; store = 1'b0; err_clr = 1'b0;
        address = 16'($urandom); store_data = 16'($urandom); dest_reg = 3'($urandom);
        prev_acked = !mis && !timed_out;
    endtask

    task automatic idle(input int n, input bit clr);
        for (int i = 0; i < n; i++) begin
            err_clr = clr && (i == 0);
            @(posedge clk);
            #1 err_clr = 1'b0;
            if (clr && i == 0) begin
                exp_mis = 0;
                exp_bus = 0;
                check("clr_misalign", 32'(misalign_err), 32'd0);
                check("clr_bus", 32'(bus_err), 32'd0);
            end
        end
        prev_acked = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        check({tag, "_wb_reg"}, 32'(wb_reg), 32'd0);
        check({tag, "_wb_data"}, 32'(wb_data), 32'd0);
        check({tag, "_misalign"}, 32'(misalign_err), 32'd0);
        check({tag, "_bus_err"}, 32'(bus_err), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit ld;
        bit st;
        int op;
        logic [15:0] a;

        #1 reset = 1'b0;
        #1;
        check_reset_outputs("rst");
        check("rst_stall", 32'(stall), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        // Directed: load with 2 BUSY cycles, store with immediate ack, misaligned load, clear.
        ref_mem[8] = 16'hBEEF;
        dev_mem[8] = 16'hBEEF;
        issue(1, 0, 16'h0010, 16'h0000, 3'd5, 2, 0);
        issue(0, 1, 16'h0020, 16'h1234, 3'd1, 1, 0);
        issue(1, 0, 16'h0011, 16'h0000, 3'd2, 1, 0);
        idle(1, 1);
        issue(0, 1, 16'h0023, 16'h5555, 3'd0, 1, 0);

        // Reset while BUSY: outputs return to reset values without a clock edge.
        prev_acked = 0;
        req_q.push_back('{addr: 15'h0030, we: 1'b0, wdata: 16'hA5A5});
        dev_lat = 0;
        chk_b2b = 0;
        load = 1'b1; store = 1'b0; address = 16'h0060; store_data = 16'hA5A5; dest_reg = 3'd2;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 10);
        check("req_before_reset", 32'(mem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("midbusy");
        check("midbusy_stall", 32'(stall), 32'd1);
        load = 1'b0;
        #1 check("midbusy_stall_off", 32'(stall), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        exp_mis = 0;
        exp_bus = 0;

        // Clean restart, then back-to-back loads.
        issue(1, 0, 16'h0060, 16'h0000, 3'd3, 1, 0);
        issue(1, 0, 16'h0010, 16'h0000, 3'd4, 3, 0);
        issue(1, 0, 16'h0022, 16'h0000, 3'd6, 2, 0);

        // Load wins over store; a new error wins over err_clr.
        issue(1, 1, 16'h0020, 16'hDEAD, 3'd7, 1, 0);
        issue(1, 0, 16'h0031, 16'h0000, 3'd1, 1, 1);
        issue(0, 1, 16'h0032, 16'h4321, 3'd1, 2, 1);

`ifdef LSU_TIMEOUT_EN
        issue(1, 0, 16'h0040, 16'h0000, 3'd2, 0, 0);
        issue(0, 1, 16'h0042, 16'h7777, 3'd2, TIMEOUT_CYCLES + 1, 0);
        idle(1, 1);
        issue(1, 0, 16'h0044, 16'h0000, 3'd5, TIMEOUT_CYCLES, 0);
`endif

        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 2);
            ld = (op == 0) || (op == 2);
            st = (op == 1) || (op == 2);
            a = 16'($urandom_range(0, 15)) << 1;
            a[0] = ($urandom_range(0, 7) == 0);
            issue(ld, st, a, 16'($urandom), 3'($urandom), $urandom_range(1, 4),
                  $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), 1'($urandom_range(0, 1)));
        end

        idle(3, 0);
        check("req_queue_drained", 32'(req_q.size()), 32'd0);
        check("wb_queue_drained", 32'(wb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
